// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-port DRAM arbiter.
// Imported by the round-robin picker and the arbiter top.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic PORT_DMEM = 1'b0;
    localparam logic PORT_IMEM = 1'b1;

    // The wait counter holds RD_LAT-1 down to 0, so it needs at least one bit.
    function automatic int rd_cnt_width(input int rd_lat);
        return (rd_lat < 2) ? 1 : $clog2(rd_lat);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-request round-robin picker.
// On a tie, the port that did not win last time is chosen.
module rr_arbiter2
    import dram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = PORT_DMEM;
        case (req)
            2'b01:   gnt_idx = PORT_DMEM;
            2'b10:   gnt_idx = PORT_IMEM;
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = PORT_DMEM;
        endcase
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter and sequencer in front of a single-port synchronous DRAM.
// One transaction at a time; all DRAM pins, acks and read data are registered.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  dram_cs,
    output logic                  dram_we,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [DATA_WIDTH-1:0] dram_wdata,
    input  logic [DATA_WIDTH-1:0] dram_rdata
);

    localparam int CNT_W = rd_cnt_width(RD_LAT);

    state_t                state_q,      state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_idx_q,    gnt_idx_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic                  dram_cs_q,    dram_cs_d;
    logic                  dram_we_q,    dram_we_d;
    logic [ADDR_WIDTH-1:0] dram_addr_q,  dram_addr_d;
    logic [DATA_WIDTH-1:0] dram_wdata_q, dram_wdata_d;
    logic                  m0_ack_q,     m0_ack_d;
    logic                  m1_ack_q,     m1_ack_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q,   m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q,   m1_rdata_d;

    logic gnt_valid;
    logic gnt_idx;
    logic finish;

    rr_arbiter2 u_rr (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // The DRAM address/data registers double as the latched request fields.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_idx_d    = gnt_idx_q;
        cnt_d        = cnt_q;
        dram_cs_d    = dram_cs_q;
        dram_we_d    = dram_we_q;
        dram_addr_d  = dram_addr_q;
        dram_wdata_d = dram_wdata_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        finish       = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    gnt_idx_d    = gnt_idx;
                    last_grant_d = gnt_idx;
                    dram_cs_d    = 1'b1;
                    dram_we_d    = (gnt_idx == PORT_IMEM) ? m1_we    : m0_we;
                    dram_addr_d  = (gnt_idx == PORT_IMEM) ? m1_addr  : m0_addr;
                    dram_wdata_d = (gnt_idx == PORT_IMEM) ? m1_wdata : m0_wdata;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (dram_we_q) begin
                    finish = 1'b1;
                end else begin
                    dram_we_d = 1'b0;
                    cnt_d     = CNT_W'(RD_LAT - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (gnt_idx_q == PORT_IMEM) begin
                        m1_rdata_d = dram_rdata;
                    end else begin
                        m0_rdata_d = dram_rdata;
                    end
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared tail of the write (ACCESS) and read (last WAIT) paths.
        if (finish) begin
            dram_cs_d = 1'b0;
            dram_we_d = 1'b0;
            m0_ack_d  = (gnt_idx_q == PORT_DMEM);
            m1_ack_d  = (gnt_idx_q == PORT_IMEM);
            state_d   = DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_IMEM;
            gnt_idx_q    <= PORT_DMEM;
            cnt_q        <= '0;
            dram_cs_q    <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_idx_q    <= gnt_idx_d;
            cnt_q        <= cnt_d;
            dram_cs_q    <= dram_cs_d;
            dram_we_q    <= dram_we_d;
            dram_addr_q  <= dram_addr_d;
            dram_wdata_q <= dram_wdata_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign dram_cs    = dram_cs_q;
    assign dram_we    = dram_we_q;
    assign dram_addr  = dram_addr_q;
    assign dram_wdata = dram_wdata_q;
    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: one instance at RD_LAT=1 with two requesters,
// one at RD_LAT=3 with a single requester, each in front of a behavioural DRAM.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        chg;
        logic [31:0] new_addr;
    } txn_t;

    typedef struct {
        logic        rd;
        logic [31:0] rdata;
        int          ack_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   check_cnt = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0 (RD_LAT=1)
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        d0_cs, d0_we;
    logic [31:0] d0_addr, d0_wdata;
    logic [31:0] d0_rdata;

    // Instance 1 (RD_LAT=3)
    logic        d1_req, d1_we;
    logic [31:0] d1_addr;
    logic        d1_m0_ack, d1_m1_ack;
    logic [31:0] d1_m0_rdata, d1_m1_rdata;
    logic        d1_cs, d1_dwe;
    logic [31:0] d1_daddr, d1_dwdata, d1_rdata;
    logic [31:0] p1 [3];

    txn_t txn_q [2][$];
    exp_t exp_q [2][$];
    int   exp_port_q [$];
    exp_t exp1_q [$];

    dram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LAT(1)) dut0 (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .dram_cs(d0_cs), .dram_we(d0_we), .dram_addr(d0_addr),
        .dram_wdata(d0_wdata), .dram_rdata(d0_rdata)
    );

    dram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LAT(3)) dut1 (
        .clk(clk), .rst(rst),
        .m0_req(d1_req), .m0_we(d1_we), .m0_addr(d1_addr), .m0_wdata(32'h0),
        .m0_ack(d1_m0_ack), .m0_rdata(d1_m0_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0),
        .m1_ack(d1_m1_ack), .m1_rdata(d1_m1_rdata),
        .dram_cs(d1_cs), .dram_we(d1_dwe), .dram_addr(d1_daddr),
        .dram_wdata(d1_dwdata), .dram_rdata(d1_rdata)
    );

    // Behavioural DRAMs: word i initialised to 0x1000_0000+i, read data
    // appears RD_LAT cycles after the sampling edge.
    logic        mem_ready = 1'b0;
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 32'h1000_0000 + 32'(i);
                mem1[i] <= 32'h1000_0000 + 32'(i);
            end
            mem_ready <= 1'b1;
        end else begin
            if (d0_cs && d0_we) mem0[d0_addr[9:2]] <= d0_wdata;
            if (d1_cs && d1_dwe) mem1[d1_daddr[9:2]] <= d1_dwdata;
        end
        d0_rdata <= (d0_cs && !d0_we) ? mem0[d0_addr[9:2]] : 32'h0;
        p1[0]    <= (d1_cs && !d1_dwe) ? mem1[d1_daddr[9:2]] : 32'h0;
        p1[1]    <= p1[0];
        p1[2]    <= p1[1];
    end
    assign d1_rdata = p1[2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        check_cnt++;
        if (act >= lo && act <= hi) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    endtask

    task automatic failNote(input string name);
        check_cnt++;
        $display("[TB] FAIL %s: got no/extra event, expected scoreboard match (cycle %0d)", name, cyc);
    endtask

    function automatic logic portAck(input int p);
        return (p == 1) ? m1_ack : m0_ack;
    endfunction

    task automatic pushTxn(input int p, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int lat, input logic chg, input logic [31:0] na);
        txn_t t;
        t.we = w; t.addr = a; t.wdata = wd; t.rdata = rd;
        t.lat = lat; t.chg = chg; t.new_addr = na;
        txn_q[p].push_back(t);
    endtask

    // Drives every queued transaction of one port, holding req until each ack.
    task automatic applyStimulus(input int p);
        txn_t t;
        exp_t e;
        int   n;
        while (txn_q[p].size() > 0) begin
            t = txn_q[p].pop_front();
            we[p]    = t.we;
            addr[p]  = t.addr;
            wdata[p] = t.wdata;
            req[p]   = 1'b1;
            e.rd      = !t.we;
            e.rdata   = t.rdata;
            e.ack_cyc = (t.lat < 0) ? -1 : cyc + t.lat;
            exp_q[p].push_back(e);
            if (t.chg) begin
                @(posedge clk); #1;
                addr[p] = t.new_addr;
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!portAck(p) && n < 60);
            if (!portAck(p)) failNote("ack_timeout");
        end
        req[p] = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor for instance 0: ack order, data, latency, pulse width, cs runs.
    initial begin : mon0
        logic [1:0] a;
        logic [1:0] prev;
        int   run;
        int   p;
        exp_t e;
        prev = 2'b00;
        run  = 0;
        forever begin
            @(negedge clk);
            a = {m1_ack, m0_ack};
            if (rst) begin
                prev = 2'b00;
                run  = 0;
            end else begin
                if (a != 2'b00) begin
                    checkOutput("ack_onehot", 32'(a == 2'b11), 32'h0);
                    p = m1_ack ? 1 : 0;
                    if (exp_port_q.size() == 0) failNote("unexpected_ack");
                    else checkOutput("grant_order", 32'(p), 32'(exp_port_q.pop_front()));
                    if (exp_q[p].size() == 0) begin
                        failNote("unexpected_port_ack");
                    end else begin
                        e = exp_q[p].pop_front();
                        if (e.rd) checkOutput(p ? "m1_rdata" : "m0_rdata", p ? m1_rdata : m0_rdata, e.rdata);
                        if (e.ack_cyc >= 0) checkOutput("ack_latency", 32'(cyc), 32'(e.ack_cyc));
                    end
                    checkOutput("ack_single_pulse", 32'(prev[p]), 32'h0);
                    checkOutput("cs_low_at_ack", 32'(d0_cs), 32'h0);
                end
                if (d0_cs) begin
                    run++;
                end else begin
                    if (run > 0) checkRange("cs_run_len", run, 1, 2);
                    run = 0;
                end
                prev = a;
            end
        end
    end

    // Monitor for instance 1 (RD_LAT=3).
    initial begin : mon1
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (d1_m0_ack || d1_m1_ack) begin
                    checkOutput("d1_ack_port", 32'({d1_m1_ack, d1_m0_ack}), 32'h1);
                    if (exp1_q.size() == 0) begin
                        failNote("d1_unexpected_ack");
                    end else begin
                        e = exp1_q.pop_front();
                        checkOutput("d1_rdata", d1_m0_rdata, e.rdata);
                        checkOutput("d1_ack_latency", 32'(cyc), 32'(e.ack_cyc));
                    end
                end
                if (d1_cs) begin
                    run++;
                end else begin
                    if (run > 0) checkOutput("d1_cs_run_len", 32'(run), 32'd4);
                    run = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        exp_t e;
        int   n;
        req = 2'b00; we = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        d1_req = 1'b0; d1_we = 1'b0; d1_addr = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkOutput("rst_dram_cs", 32'(d0_cs), 32'h0);
        checkOutput("rst_dram_we", 32'(d0_we), 32'h0);
        checkOutput("rst_dram_addr", d0_addr, 32'h0);
        checkOutput("rst_dram_wdata", d0_wdata, 32'h0);
        checkOutput("rst_acks", 32'({m1_ack, m0_ack}), 32'h0);
        checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
        checkOutput("rst_m1_rdata", m1_rdata, 32'h0);
        checkOutput("rst_state", 32'(dut0.state_q), 32'(IDLE));
        checkOutput("rst_last_grant", 32'(dut0.last_grant_q), 32'h1);

        // m0 write then read of 0x10
        exp_port_q.push_back(0);
        exp_port_q.push_back(0);
        pushTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 2, 1'b0, 32'h0);
        applyStimulus(0);
        @(posedge clk); #1;
        pushTxn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 1'b0, 32'h0);
        applyStimulus(0);

        // Simultaneous reads right after reset: m0 first, m1 four cycles later
        @(posedge clk); #1;
        doReset();
        exp_port_q.push_back(0);
        exp_port_q.push_back(1);
        pushTxn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 1'b0, 32'h0);
        pushTxn(1, 1'b0, 32'h20, 32'h0, 32'h1000_0008, 7, 1'b0, 32'h0);
        fork
            applyStimulus(0);
            applyStimulus(1);
        join

        // Both ports requesting continuously for 8 transactions
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) exp_port_q.push_back(i % 2);
        pushTxn(0, 1'b1, 32'h100, 32'hCAFE0001, 32'h0, -1, 1'b0, 32'h0);
        pushTxn(0, 1'b0, 32'h100, 32'h0, 32'hCAFE0001, -1, 1'b0, 32'h0);
        pushTxn(0, 1'b1, 32'h104, 32'hCAFE0002, 32'h0, -1, 1'b0, 32'h0);
        pushTxn(0, 1'b0, 32'h104, 32'h0, 32'hCAFE0002, -1, 1'b0, 32'h0);
        pushTxn(1, 1'b0, 32'h00, 32'h0, 32'h1000_0000, -1, 1'b0, 32'h0);
        pushTxn(1, 1'b0, 32'h04, 32'h0, 32'h1000_0001, -1, 1'b0, 32'h0);
        pushTxn(1, 1'b0, 32'h08, 32'h0, 32'h1000_0002, -1, 1'b0, 32'h0);
        pushTxn(1, 1'b0, 32'h0C, 32'h0, 32'h1000_0003, -1, 1'b0, 32'h0);
        fork
            applyStimulus(0);
            applyStimulus(1);
        join

        // m1 changes its address after the grant; 0x20 must still be read
        @(posedge clk); #1;
        exp_port_q.push_back(1);
        pushTxn(1, 1'b0, 32'h20, 32'h0, 32'h1000_0008, 3, 1'b1, 32'h40);
        applyStimulus(1);

        // Reset during the ACCESS cycle of a write to 0x30
        @(posedge clk); #1;
        we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hBADC0FFE; req[0] = 1'b1;
        @(posedge clk); #2;
        checkOutput("pre_rst_dram_we", 32'(d0_we), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_dram_we", 32'(d0_we), 32'h0);
        checkOutput("async_rst_dram_cs", 32'(d0_cs), 32'h0);
        req[0] = 1'b0; we[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("post_rst_state", 32'(dut0.state_q), 32'(IDLE));
        checkOutput("post_rst_m0_ack", 32'(m0_ack), 32'h0);
        exp_port_q.push_back(0);
        pushTxn(0, 1'b0, 32'h30, 32'h0, 32'h1000_000C, 3, 1'b0, 32'h0);
        applyStimulus(0);

        // RD_LAT=3 instance: ack 5 cycles after the req cycle, cs high 4 cycles
        @(posedge clk); #1;
        d1_we = 1'b0; d1_addr = 32'h08; d1_req = 1'b1;
        e.rd = 1'b1; e.rdata = 32'h1000_0002; e.ack_cyc = cyc + 5;
        exp1_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d1_m0_ack && n < 60);
        if (!d1_m0_ack) failNote("d1_ack_timeout");
        d1_req = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        checkOutput("sb_port_empty", 32'(exp_port_q.size()), 32'h0);
        checkOutput("sb_d1_empty", 32'(exp1_q.size()), 32'h0);
        checkOutput("d1_m1_rdata_untouched", d1_m1_rdata, 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
